// File: rtl/llc_cmd_sched.sv
// rtl/llc_cmd_sched.sv - three-requester command scheduler in front of the LLC model
// One holding register per requester, priority mnt > snp > cpu with snoop-streak relief.
module llc_cmd_sched #(
    parameter int MAX_SNOOP_STREAK = 4,
    parameter int TIMEOUT          = 16,
    parameter int CNT_W            = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_valid,
    output logic             cpu_ready,
    input  logic [3:0]       cpu_op,
    input  logic [31:0]      cpu_addr,
    input  logic             snp_valid,
    output logic             snp_ready,
    input  logic [3:0]       snp_op,
    input  logic [31:0]      snp_addr,
    input  logic             mnt_valid,
    output logic             mnt_ready,
    input  logic [3:0]       mnt_op,
    output logic             llc_req,
    output logic [3:0]       llc_op,
    output logic [31:0]      llc_addr,
    input  logic             llc_done,
    output logic [1:0]       grant_src,
    output logic             busy,
    output logic             illegal_op,
    output logic             timeout_err,
    output logic [CNT_W-1:0] cpu_grants,
    output logic [CNT_W-1:0] snp_grants
);
    localparam int SW = $clog2(MAX_SNOOP_STREAK + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             cpu_v_q, cpu_v_d, snp_v_q, snp_v_d, mnt_v_q, mnt_v_d;
    logic [3:0]       cpu_op_q, cpu_op_d, snp_op_q, snp_op_d, mnt_op_q, mnt_op_d;
    logic [31:0]      cpu_addr_q, cpu_addr_d, snp_addr_q, snp_addr_d;
    logic [3:0]       op_q, op_d;
    logic [31:0]      addr_q, addr_d;
    logic [1:0]       src_q, src_d;
    logic             ill_q, ill_d, terr_q, terr_d;
    logic [CNT_W-1:0] cpu_cnt_q, cpu_cnt_d, snp_cnt_q, snp_cnt_d;
    logic [SW-1:0]    streak_q, streak_d;
    logic [TW-1:0]    tmo_q, tmo_d;

    logic cpu_acc, snp_acc, mnt_acc;
    logic cpu_legal, snp_legal, mnt_legal;
    logic gnt_mnt, gnt_snp, gnt_cpu, streak_full;

    assign cpu_ready = ~cpu_v_q;
    assign snp_ready = ~snp_v_q;
    assign mnt_ready = ~mnt_v_q;

    assign cpu_acc = cpu_valid && !cpu_v_q;
    assign snp_acc = snp_valid && !snp_v_q;
    assign mnt_acc = mnt_valid && !mnt_v_q;

    assign cpu_legal = (cpu_op <= 4'd2);
    assign snp_legal = (snp_op >= 4'd3) && (snp_op <= 4'd6);
    assign mnt_legal = (mnt_op == 4'd8) || (mnt_op == 4'd9);

    // A full streak hands the slot to a waiting cpu command; maintenance still wins.
    assign streak_full = (streak_q == SW'(MAX_SNOOP_STREAK));
    assign gnt_mnt = mnt_v_q;
    assign gnt_snp = !mnt_v_q && snp_v_q && !(streak_full && cpu_v_q);
    assign gnt_cpu = !mnt_v_q && !gnt_snp && cpu_v_q;

    always_comb begin
        state_d    = state_q;
        cpu_v_d    = cpu_v_q;
        snp_v_d    = snp_v_q;
        mnt_v_d    = mnt_v_q;
        cpu_op_d   = cpu_op_q;
        snp_op_d   = snp_op_q;
        mnt_op_d   = mnt_op_q;
        cpu_addr_d = cpu_addr_q;
        snp_addr_d = snp_addr_q;
        op_d       = op_q;
        addr_d     = addr_q;
        src_d      = src_q;
        terr_d     = terr_q;
        cpu_cnt_d  = cpu_cnt_q;
        snp_cnt_d  = snp_cnt_q;
        streak_d   = streak_q;
        tmo_d      = tmo_q;
        ill_d      = (cpu_acc && !cpu_legal) || (snp_acc && !snp_legal) || (mnt_acc && !mnt_legal);

        if (cpu_acc && cpu_legal) begin
            cpu_v_d    = 1'b1;
            cpu_op_d   = cpu_op;
            cpu_addr_d = cpu_addr;
        end
        if (snp_acc && snp_legal) begin
            snp_v_d    = 1'b1;
            snp_op_d   = snp_op;
            snp_addr_d = snp_addr;
        end
        if (mnt_acc && mnt_legal) begin
            mnt_v_d  = 1'b1;
            mnt_op_d = mnt_op;
        end

        case (state_q)
            S_IDLE: begin
                if (gnt_mnt) begin
                    state_d = S_ISSUE;
                    mnt_v_d = 1'b0;
                    op_d    = mnt_op_q;
                    addr_d  = 32'd0;
                    src_d   = 2'd3;
                    if (mnt_op_q == 4'd8) begin
                        cpu_cnt_d = '0;
                        snp_cnt_d = '0;
                        terr_d    = 1'b0;
                        streak_d  = '0;
                    end else if (!cpu_v_q) begin
                        streak_d = '0;
                    end
                end else if (gnt_snp) begin
                    state_d = S_ISSUE;
                    snp_v_d = 1'b0;
                    op_d    = snp_op_q;
                    addr_d  = snp_addr_q;
                    src_d   = 2'd2;
                    if (snp_cnt_q != '1) snp_cnt_d = snp_cnt_q + CNT_W'(1);
                    if (!cpu_v_q) streak_d = '0;
                    else if (!streak_full) streak_d = streak_q + SW'(1);
                end else if (gnt_cpu) begin
                    state_d  = S_ISSUE;
                    cpu_v_d  = 1'b0;
                    op_d     = cpu_op_q;
                    addr_d   = cpu_addr_q;
                    src_d    = 2'd1;
                    streak_d = '0;
                    if (cpu_cnt_q != '1) cpu_cnt_d = cpu_cnt_q + CNT_W'(1);
                end
            end
            S_ISSUE: begin
                tmo_d   = '0;
                state_d = llc_done ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (llc_done) begin
                    state_d = S_IDLE;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    terr_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cpu_v_q    <= 1'b0;
            snp_v_q    <= 1'b0;
            mnt_v_q    <= 1'b0;
            cpu_op_q   <= '0;
            snp_op_q   <= '0;
            mnt_op_q   <= '0;
            cpu_addr_q <= '0;
            snp_addr_q <= '0;
            op_q       <= '0;
            addr_q     <= '0;
            src_q      <= '0;
            ill_q      <= 1'b0;
            terr_q     <= 1'b0;
            cpu_cnt_q  <= '0;
            snp_cnt_q  <= '0;
            streak_q   <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            cpu_v_q    <= cpu_v_d;
            snp_v_q    <= snp_v_d;
            mnt_v_q    <= mnt_v_d;
            cpu_op_q   <= cpu_op_d;
            snp_op_q   <= snp_op_d;
            mnt_op_q   <= mnt_op_d;
            cpu_addr_q <= cpu_addr_d;
            snp_addr_q <= snp_addr_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            src_q      <= src_d;
            ill_q      <= ill_d;
            terr_q     <= terr_d;
            cpu_cnt_q  <= cpu_cnt_d;
            snp_cnt_q  <= snp_cnt_d;
            streak_q   <= streak_d;
            tmo_q      <= tmo_d;
        end
    end

    assign llc_req     = (state_q == S_ISSUE);
    assign busy        = (state_q != S_IDLE);
    assign llc_op      = op_q;
    assign llc_addr    = addr_q;
    assign grant_src   = src_q;
    assign illegal_op  = ill_q;
    assign timeout_err = terr_q;
    assign cpu_grants  = cpu_cnt_q;
    assign snp_grants  = snp_cnt_q;
endmodule

// File: tb/tb_llc_cmd_sched.sv
// tb/tb_llc_cmd_sched.sv - directed self-checking bench for llc_cmd_sched
module tb_llc_cmd_sched;
    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_valid, cpu_ready, snp_valid, snp_ready, mnt_valid, mnt_ready;
    logic [3:0]  cpu_op, snp_op, mnt_op, llc_op;
    logic [31:0] cpu_addr, snp_addr, llc_addr;
    logic        llc_req, llc_done, busy, illegal_op, timeout_err;
    logic [1:0]  grant_src;
    logic [15:0] cpu_grants, snp_grants;

    int checks = 0;
    int errors = 0;
    int n;
    logic [1:0] got[6];
    logic [1:0] exp_seq[6];

    llc_cmd_sched #(.MAX_SNOOP_STREAK(4), .TIMEOUT(16), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_op(cpu_op), .cpu_addr(cpu_addr),
        .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_op(snp_op), .snp_addr(snp_addr),
        .mnt_valid(mnt_valid), .mnt_ready(mnt_ready), .mnt_op(mnt_op),
        .llc_req(llc_req), .llc_op(llc_op), .llc_addr(llc_addr), .llc_done(llc_done),
        .grant_src(grant_src), .busy(busy), .illegal_op(illegal_op), .timeout_err(timeout_err),
        .cpu_grants(cpu_grants), .snp_grants(snp_grants)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_valid = 0; cpu_op = 0; cpu_addr = 0;
        snp_valid = 0; snp_op = 0; snp_addr = 0;
        mnt_valid = 0; mnt_op = 0; llc_done = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 0;
        step();
        step();
        reset = 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 0;
        idle_inputs();
        #3;
        check("rst_llc_req", llc_req, 0);
        check("rst_busy", busy, 0);
        check("rst_grant_src", grant_src, 0);
        check("rst_llc_op", llc_op, 0);
        check("rst_llc_addr", llc_addr, 0);
        check("rst_cnts", {cpu_grants, snp_grants}, 0);
        check("rst_flags", {illegal_op, timeout_err}, 0);
        step(); step();
        reset = 1;
        step();
        check("rst_readys", {cpu_ready, snp_ready, mnt_ready}, 3'b111);

        // single cpu read, done in the WAIT cycle
        cpu_valid = 1; cpu_op = 0; cpu_addr = 32'h1000_0040;
        step();
        cpu_valid = 0;
        check("t1_ready_low", cpu_ready, 0);
        check("t1_no_req_yet", llc_req, 0);
        step();
        check("t1_req", llc_req, 1);
        check("t1_op", llc_op, 0);
        check("t1_addr", llc_addr, 32'h1000_0040);
        check("t1_src", grant_src, 1);
        check("t1_cpu_grants", cpu_grants, 1);
        check("t1_ready_back", cpu_ready, 1);
        step();
        check("t1_wait_req", llc_req, 0);
        check("t1_wait_busy", busy, 1);
        llc_done = 1;
        step();
        llc_done = 0;
        check("t1_idle", busy, 0);

        // snp beats cpu when both arrive together
        do_reset();
        cpu_valid = 1; cpu_op = 1; cpu_addr = 32'h1100_0000;
        snp_valid = 1; snp_op = 4; snp_addr = 32'h2200_0000;
        step();
        cpu_valid = 0; snp_valid = 0;
        step();
        check("t2_src_first", grant_src, 2);
        check("t2_op_first", llc_op, 4);
        check("t2_addr_first", llc_addr, 32'h2200_0000);
        llc_done = 1;
        step();
        llc_done = 0;
        check("t2_gap_idle", llc_req, 0);
        step();
        check("t2_src_second", grant_src, 1);
        check("t2_op_second", llc_op, 1);
        check("t2_addr_second", llc_addr, 32'h1100_0000);
        check("t2_cnts", {cpu_grants, snp_grants}, {16'd1, 16'd1});

        // snoop streak relief
        do_reset();
        exp_seq = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2};
        cpu_valid = 1; cpu_op = 2; cpu_addr = 32'h2000_0000;
        snp_valid = 1; snp_op = 3; snp_addr = 32'h3000_0000;
        llc_done = 1;
        step();
        cpu_valid = 0;
        n = 0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            step();
            if (llc_req) begin
                got[n] = grant_src;
                n++;
            end
        end
        snp_valid = 0;
        check("t3_issue_count", n, 6);
        for (int i = 0; i < 6; i++) check($sformatf("t3_seq%0d", i), got[i], exp_seq[i]);
        check("t3_cnts", {cpu_grants, snp_grants}, {16'd1, 16'd5});
        step();
        llc_done = 0;

        // timeout, pending cpu issued afterwards, op 8 clears
        do_reset();
        cpu_valid = 1; cpu_op = 0; cpu_addr = 32'h4000_0000;
        snp_valid = 1; snp_op = 5; snp_addr = 32'h5000_0000;
        step();
        cpu_valid = 0; snp_valid = 0;
        step();
        check("t4_snp_issue", {llc_req, grant_src}, {1'b1, 2'd2});
        repeat (16) step();
        check("t4_wait16_busy", busy, 1);
        check("t4_wait16_terr", timeout_err, 0);
        step();
        check("t4_idle_after_to", busy, 0);
        check("t4_terr_set", timeout_err, 1);
        step();
        check("t4_cpu_issue", {llc_req, grant_src}, {1'b1, 2'd1});
        check("t4_cpu_addr", llc_addr, 32'h4000_0000);
        llc_done = 1;
        step();
        llc_done = 0;
        mnt_valid = 1; mnt_op = 8;
        step();
        mnt_valid = 0;
        check("t4_terr_held", timeout_err, 1);
        step();
        check("t4_mnt_issue", {llc_req, grant_src, llc_op}, {1'b1, 2'd3, 4'd8});
        check("t4_mnt_addr", llc_addr, 0);
        check("t4_terr_clr", timeout_err, 0);
        check("t4_cnts_clr", {cpu_grants, snp_grants}, 0);
        llc_done = 1;
        step();
        llc_done = 0;

        // illegal ops, then mnt over snp at op boundaries
        do_reset();
        cpu_valid = 1; cpu_op = 5; cpu_addr = 32'h9000_0000;
        step();
        cpu_valid = 0;
        check("t5_ill_cpu", illegal_op, 1);
        check("t5_cpu_not_held", cpu_ready, 1);
        step();
        check("t5_ill_drop1", {illegal_op, llc_req, busy}, 0);
        mnt_valid = 1; mnt_op = 7;
        step();
        mnt_valid = 0;
        check("t5_ill_mnt", illegal_op, 1);
        check("t5_mnt_not_held", mnt_ready, 1);
        step();
        check("t5_ill_drop2", {illegal_op, llc_req, busy}, 0);
        check("t5_cnts", {cpu_grants, snp_grants}, 0);
        snp_valid = 1; snp_op = 6; snp_addr = 32'h6000_0000;
        mnt_valid = 1; mnt_op = 9;
        llc_done = 1;
        step();
        snp_valid = 0; mnt_valid = 0;
        check("t5_no_ill", illegal_op, 0);
        step();
        check("t5_mnt_first", {llc_req, grant_src, llc_op}, {1'b1, 2'd3, 4'd9});
        check("t5_mnt_addr", llc_addr, 0);
        step();
        step();
        check("t5_snp_second", {llc_req, grant_src, llc_op}, {1'b1, 2'd2, 4'd6});
        check("t5_snp_addr", llc_addr, 32'h6000_0000);
        check("t5_snp_cnt", snp_grants, 1);
        step();
        llc_done = 0;

        // reset during WAIT with a snoop held
        do_reset();
        cpu_valid = 1; cpu_op = 1; cpu_addr = 32'h7000_0000;
        step();
        cpu_valid = 0;
        step();
        snp_valid = 1; snp_op = 3; snp_addr = 32'h7100_0000;
        step();
        snp_valid = 0;
        check("t6_in_wait", {busy, snp_ready}, 2'b10);
        reset = 0;
        #1;
        check("t6_async_clear", {llc_req, busy, grant_src}, 0);
        #1;
        reset = 1;
        step();
        check("t6_readys", {cpu_ready, snp_ready, mnt_ready}, 3'b111);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t6_lost%0d", i), {llc_req, busy}, 0);
            step();
        end

        // reset mid-ISSUE
        cpu_valid = 1; cpu_op = 2; cpu_addr = 32'h7200_0000;
        step();
        cpu_valid = 0;
        step();
        check("t6_issue", llc_req, 1);
        reset = 0;
        #1;
        check("t6_issue_clear", {llc_req, busy, grant_src}, 0);
        #1;
        reset = 1;
        step();
        check("t6_issue_ready", {cpu_ready, busy}, 2'b10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/llc_cmd_sched.md
Name: llc_cmd_sched

Overview:
Front-end scheduler for the LLC model. It accepts trace commands from three requesters: processor side (ops 0-2), bus-snoop side (ops 3-6) and maintenance (op 8 clear, op 9 print). It buffers one command per requester and issues one command at a time to the LLC. It arbitrates by priority with anti-starvation, tracks completion with a timeout, and reports grant statistics.

Parameters:
MAX_SNOOP_STREAK, 4, consecutive snoop grants allowed while a processor command waits
TIMEOUT, 16, cycles to wait for llc_done before abandoning a command
CNT_W, 16, width of grant counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
cpu_valid  in  1  processor command valid
cpu_ready  out  1  processor holding register empty
cpu_op  in  4  processor op code
cpu_addr  in  32  processor address
snp_valid  in  1  snoop command valid
snp_ready  out  1  snoop holding register empty
snp_op  in  4  snoop op code
snp_addr  in  32  snoop address
mnt_valid  in  1  maintenance command valid
mnt_ready  out  1  maintenance holding register empty
mnt_op  in  4  maintenance op code
llc_req  out  1  one-cycle issue strobe to the LLC
llc_op  out  4  issued op
llc_addr  out  32  issued address; 0 for maintenance
llc_done  in  1  LLC completion
grant_src  out  2  source of the last issue: 0 none, 1 cpu, 2 snp, 3 mnt
busy  out  1  state is not IDLE
illegal_op  out  1  one-cycle pulse when an out-of-range op is dropped
timeout_err  out  1  sticky; set on a WAIT timeout
cpu_grants  out  CNT_W  saturating count of cpu issues
snp_grants  out  CNT_W  saturating count of snoop issues

Behaviour:
- Reset (asynchronous, while reset=0):
  - State goes to IDLE and all holding registers are emptied.
  - llc_req=0, llc_op=0, llc_addr=0, grant_src=0.
  - illegal_op=0, timeout_err=0, counters=0, streak=0.
  - Reset mid-WAIT abandons the command; llc_req drops immediately.
- Ready and accept:
  - Each xxx_ready is the combinational inverse of its holding-register valid, so it is 1 from the first cycle after reset.
  - A command is accepted on the rising edge where valid&&ready.
- Legal op ranges: cpu 0-2, snp 3-6, mnt 8-9.
  - An illegal op is accepted but not stored.
  - illegal_op pulses in the cycle after the accept edge.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE, when any holding register is valid:
  - Priority is mnt > snp > cpu.
  - Exception: if streak==MAX_SNOOP_STREAK and the cpu register is valid, cpu wins over snp. mnt still wins.
  - At the next edge: go to ISSUE, latch llc_op/llc_addr/grant_src, and clear the winning holding register. Its ready reasserts in the ISSUE cycle.
- ISSUE: llc_req=1 for exactly this cycle.
  - If llc_done=1 in this cycle, go to IDLE.
  - Otherwise go to WAIT and load the timeout counter with 0.
- WAIT: llc_req=0.
  - llc_done=1 returns the FSM to IDLE.
  - If the counter reaches TIMEOUT-1 without llc_done: set timeout_err and go to IDLE; the command is dropped.
  - llc_done in IDLE is ignored.
- Latency: accept edge E0, decision in the IDLE cycle, llc_req high in the cycle after edge E1. The minimum command-to-command spacing is 2 cycles (ISSUE, then IDLE).
- Streak:
  - Increments when snp is granted while the cpu register is valid; saturates at MAX_SNOOP_STREAK.
  - Clears to 0 on a cpu grant, on any grant made while the cpu register is empty, and on an issued op 8.
- Issued op 8 additionally clears cpu_grants, snp_grants and timeout_err at the ISSUE edge.
  - Commands already held are not flushed.
- Counters update at the ISSUE edge and saturate at all-ones.
- A new accept to a source and that source's issue cannot collide: ready=0 whenever its register holds the command being granted.

Test Plan:
- Single cpu read (op 0, addr 0x1000_0040) from IDLE with llc_done one cycle after llc_req -> llc_req high 1 cycle after the accept edge with llc_op=0, llc_addr=0x1000_0040, grant_src=1, cpu_grants=1; busy low again 3 cycles after the accept edge.
- cpu op 1 and snp op 4 accepted on the same edge -> snp issued first (grant_src=2), cpu second; snp_grants=1, cpu_grants=1.
- Snoops back-to-back continuously with cpu op 2 pending, MAX_SNOOP_STREAK=4 -> exactly 4 snoop issues, then the cpu issue, then snoops resume.
- llc_done never asserted after issue, TIMEOUT=16 -> timeout_err=1 after 16 WAIT cycles, FSM back in IDLE, next pending command issued; a later issued op 8 clears timeout_err.
- cpu_op=5 and mnt_op=7 -> each accepted, illegal_op pulses once each, no llc_req, counters unchanged.
- Assert reset low in WAIT and mid-ISSUE -> llc_req, busy and grant_src go to 0 asynchronously; all readys are 1 on the first cycle after release; held commands are lost.
